// File: rtl/spi_peripheral_if.sv
// SPI pin bundle between an external controller (master) and spi_peripheral (slave).
interface spi_peripheral_if;
    logic sclk;
    logic copi;
    logic ncs;
    logic cipo;

    modport master (output sclk, output copi, output ncs, input cipo);
    modport slave  (input sclk, input copi, input ncs, output cipo);
endinterface

// File: rtl/spi_peripheral.sv
// SPI mode-0 target holding the five PWM configuration registers (16-bit write frames).
// Define SPI_READBACK_EN to enable register readback on cipo; otherwise cipo is tied low.
module spi_peripheral (
    input  logic                   clk,
    input  logic                   rst,
    spi_peripheral_if.slave        spi,
    output logic [7:0]             en_reg_out_7_0_o,
    output logic [7:0]             en_reg_out_15_8_o,
    output logic [7:0]             en_reg_pwm_7_0_o,
    output logic [7:0]             en_reg_pwm_15_8_o,
    output logic [7:0]             pwm_duty_cycle_o,
    output logic                   wr_strobe_o
);

    typedef enum logic [1:0] {StIdle, StShift, StCommit} state_e;

    state_e      state_q, state_d;
    logic [2:0]  sclk_sync_q;
    logic [1:0]  copi_sync_q;
    logic [2:0]  ncs_sync_q;
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] shift_q, shift_d;
    logic [7:0]  regs_q [5];
    logic [7:0]  regs_d [5];
    logic        strobe_q, strobe_d;

    logic sclk_rise;
    logic ncs_fall;
    logic ncs_rise;

    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign ncs_fall  = ~ncs_sync_q[1] & ncs_sync_q[2];
    assign ncs_rise  = ncs_sync_q[1] & ~ncs_sync_q[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= 3'b000;
            copi_sync_q <= 2'b00;
            ncs_sync_q  <= 3'b111;
        end else begin
            sclk_sync_q <= {sclk_sync_q[1:0], spi.sclk};
            copi_sync_q <= {copi_sync_q[0], spi.copi};
            ncs_sync_q[1:0] <= {ncs_sync_q[0], spi.ncs};
            // History held during COMMIT so a new frame start there is seen in IDLE.
            if (state_q != StCommit) begin
                ncs_sync_q[2] <= ncs_sync_q[1];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        regs_d   = regs_q;
        strobe_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ncs_fall) begin
                    state_d = StShift;
                    cnt_d   = 5'd0;
                    shift_d = 16'h0000;
                end
            end
            StShift: begin
                if (ncs_rise) begin
                    state_d = StCommit;
                    if (cnt_q == 5'd16 && shift_q[15] && shift_q[14:8] <= 7'd4) begin
                        for (int i = 0; i < 5; i++) begin
                            if (shift_q[10:8] == 3'(i)) begin
                                regs_d[i] = shift_q[7:0];
                            end
                        end
                        strobe_d = 1'b1;
                    end
                end else if (sclk_rise && !ncs_sync_q[1]) begin
                    shift_d = {shift_q[14:0], copi_sync_q[1]};
                    if (cnt_q != 5'd17) begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            StCommit: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= 5'd0;
            shift_q  <= 16'h0000;
            strobe_q <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            strobe_q <= strobe_d;
            regs_q   <= regs_d;
        end
    end

`ifdef SPI_READBACK_EN
    logic [7:0] tx_q, tx_d;
    logic       tx_act_q, tx_act_d;
    logic       cipo_q, cipo_d;
    logic       sclk_fall;
    logic [6:0] rd_addr;

    assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
    // Address byte as it stands once the 8th bit is being shifted in.
    assign rd_addr   = {shift_q[5:0], copi_sync_q[1]};

    always_comb begin
        tx_d     = tx_q;
        tx_act_d = tx_act_q;
        cipo_d   = cipo_q;
        if (ncs_sync_q[1]) begin
            tx_act_d = 1'b0;
            cipo_d   = 1'b0;
        end else if (state_q == StShift) begin
            if (sclk_rise && cnt_q == 5'd7) begin
                if (!shift_q[6]) begin
                    tx_act_d = 1'b1;
                    tx_d     = 8'h00;
                    for (int i = 0; i < 5; i++) begin
                        if (rd_addr == 7'(i)) begin
                            tx_d = regs_q[i];
                        end
                    end
                end
            end else if (sclk_fall && tx_act_q) begin
                cipo_d = tx_q[7];
                tx_d   = {tx_q[6:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_q     <= 8'h00;
            tx_act_q <= 1'b0;
            cipo_q   <= 1'b0;
        end else begin
            tx_q     <= tx_d;
            tx_act_q <= tx_act_d;
            cipo_q   <= cipo_d;
        end
    end

    assign spi.cipo = cipo_q;
`else
    assign spi.cipo = 1'b0;
`endif

    assign en_reg_out_7_0_o  = regs_q[0];
    assign en_reg_out_15_8_o = regs_q[1];
    assign en_reg_pwm_7_0_o  = regs_q[2];
    assign en_reg_pwm_15_8_o = regs_q[3];
    assign pwm_duty_cycle_o  = regs_q[4];
    assign wr_strobe_o       = strobe_q;

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed self-checking bench for spi_peripheral; honours SPI_READBACK_EN when defined.
module tb_spi_peripheral;

`ifdef SPI_READBACK_EN
    localparam int Half    = 4;
    localparam int MinHalf = 4;
`else
    localparam int Half    = 4;
    localparam int MinHalf = 3;
`endif

    logic clk = 1'b0;
    logic rst;
    logic sclk, copi, ncs;
    logic cipo;
    logic [7:0] r0, r1, r2, r3, r4;
    logic strobe;

    spi_peripheral_if spi_bus ();

    assign spi_bus.sclk = sclk;
    assign spi_bus.copi = copi;
    assign spi_bus.ncs  = ncs;
    assign cipo         = spi_bus.cipo;

    spi_peripheral dut (
        .clk               (clk),
        .rst               (rst),
        .spi               (spi_bus),
        .en_reg_out_7_0_o  (r0),
        .en_reg_out_15_8_o (r1),
        .en_reg_pwm_7_0_o  (r2),
        .en_reg_pwm_15_8_o (r3),
        .pwm_duty_cycle_o  (r4),
        .wr_strobe_o       (strobe)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int n_strb;
    int first_strb;
    logic [15:0] rx;
    logic [7:0]  exp_r [5];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " reg0"}, {8'h00, r0}, {8'h00, exp_r[0]});
        chk({tag, " reg1"}, {8'h00, r1}, {8'h00, exp_r[1]});
        chk({tag, " reg2"}, {8'h00, r2}, {8'h00, exp_r[2]});
        chk({tag, " reg3"}, {8'h00, r3}, {8'h00, exp_r[3]});
        chk({tag, " reg4"}, {8'h00, r4}, {8'h00, exp_r[4]});
    endtask

    task automatic frame_start();
        @(negedge clk);
        ncs = 1'b0;
        rx  = 16'h0000;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_bits(input logic [16:0] word, input int n, input int half);
        for (int i = n - 1; i >= 0; i--) begin
            copi = word[i];
            repeat (half) @(negedge clk);
            sclk = 1'b1;
            rx   = {rx[14:0], cipo};
            repeat (half) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    // Raises ncs and counts strobes over the next 6 clk cycles.
    task automatic frame_end(input int half);
        repeat (half) @(negedge clk);
        ncs        = 1'b1;
        copi       = 1'b0;
        n_strb     = 0;
        first_strb = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (strobe === 1'b1) begin
                n_strb++;
                if (first_strb == 0) first_strb = k;
            end
        end
    endtask

    task automatic xfer(input logic [16:0] word, input int n, input int half);
        frame_start();
        send_bits(word, n, half);
        frame_end(half);
    endtask

    initial begin
        rst  = 1'b1;
        sclk = 1'b0;
        copi = 1'b0;
        ncs  = 1'b1;
        for (int i = 0; i < 5; i++) exp_r[i] = 8'h00;
        repeat (4) @(negedge clk);
        check_all("reset");
        chk("reset cipo", {15'd0, cipo}, 16'h0000);
        chk("reset strobe", {15'd0, strobe}, 16'h0000);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        xfer(17'h080F0, 16, Half);
        exp_r[0] = 8'hF0;
        chk("w80F0 strobes", 16'(n_strb), 16'd1);
        chk("w80F0 latency", 16'(first_strb), 16'd3);
        check_all("w80F0");

        xfer(17'h08455, 16, Half);
        exp_r[4] = 8'h55;
        chk("w8455 strobes", 16'(n_strb), 16'd1);
        xfer(17'h083AA, 16, Half);
        exp_r[3] = 8'hAA;
        chk("w83AA strobes", 16'(n_strb), 16'd1);
        check_all("two writes");

        xfer(17'h08512, 16, Half);
        chk("addr5 strobes", 16'(n_strb), 16'd0);
        check_all("addr5");
        xfer(17'h00012, 16, Half);
        chk("read strobes", 16'(n_strb), 16'd0);
        check_all("read");
`ifndef SPI_READBACK_EN
        chk("read cipo tied", rx, 16'h0000);
`endif
        xfer(17'h04011, 15, Half);
        chk("15bit strobes", 16'(n_strb), 16'd0);
        check_all("15bit");
        xfer(17'h10222, 17, Half);
        chk("17bit strobes", 16'(n_strb), 16'd0);
        check_all("17bit");

        frame_start();
        send_bits(17'h00102, 9, Half);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) exp_r[i] = 8'h00;
        send_bits(17'h00055, 7, Half);
        frame_end(Half);
        chk("rst midframe strobes", 16'(n_strb), 16'd0);
        check_all("rst midframe");
        xfer(17'h08133, 16, Half);
        exp_r[1] = 8'h33;
        chk("w8133 strobes", 16'(n_strb), 16'd1);
        check_all("w8133");

`ifdef SPI_READBACK_EN
        xfer(17'h08407, 16, Half);
        exp_r[4] = 8'h07;
        xfer(17'h00400, 16, Half);
        chk("rd4 data", {8'h00, rx[7:0]}, 16'h0007);
        chk("rd4 hdr bits", {8'h00, rx[15:8]}, 16'h0000);
        chk("rd4 strobes", 16'(n_strb), 16'd0);
        xfer(17'h00600, 16, Half);
        chk("rd6 data", rx, 16'h0000);
        check_all("readback");
`endif

        for (int round = 0; round < 2; round++) begin
            for (int a = 0; a < 5; a++) begin
                logic [7:0] d;
                d = 8'($urandom);
                xfer({1'b0, 1'b1, 7'(a), d}, 16, MinHalf);
                exp_r[a] = d;
                chk("rand strobes", 16'(n_strb), 16'd1);
            end
        end
        check_all("rand");

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
